// File: rtl/pcr_clock_counter.sv
// Local 27 MHz MPEG-2 PCR clock: edge-detects the divided clock, counts base/ext,
// loads and locks to stream PCR samples. Define PCR_JITTER_EN to enable the jitter monitor.
module pcr_clock_counter #(
   parameter int EXT_MOD        = 300,
   parameter int BASE_WIDTH     = 33,
   parameter int EXT_WIDTH      = 9,
   parameter int JITTER_WIDTH   = 16,
   parameter int DISC_THRESHOLD = 2700
) (
   input  logic                           clk2,
   input  logic                           rst,
   input  logic                           clk_pulse_in,
   input  logic                           pcr_load_valid,
   output logic                           pcr_load_ready,
   input  logic [BASE_WIDTH-1:0]          pcr_load_base,
   input  logic [EXT_WIDTH-1:0]           pcr_load_ext,
   output logic [BASE_WIDTH-1:0]          pcr_base,
   output logic [EXT_WIDTH-1:0]           pcr_ext,
   output logic                           tick,
   output logic                           locked,
   output logic                           load_error,
   output logic                           discontinuity,
   output logic signed [JITTER_WIDTH-1:0] jitter,
   output logic                           jitter_valid
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state_q;
   logic                  prev_q, tick_q, ready_q, load_error_q, disc_q;
   logic [BASE_WIDTH-1:0] base_q, base_d;
   logic [EXT_WIDTH-1:0]  ext_q, ext_d;

   logic                  rise, accept, load_bad, load_ok, disc_d;
   logic [BASE_WIDTH-1:0] db;
   logic signed [31:0]    ext_diff, err;
   logic                  err_oor;

   // NOTE: every signal driven here gets a default first, so no path leaves a latch.
   always_comb begin
      rise     = clk_pulse_in & ~prev_q;
      accept   = pcr_load_valid & ready_q;
      load_bad = accept & (pcr_load_ext >= EXT_WIDTH'(EXT_MOD));
      load_ok  = accept & ~load_bad;

      base_d = base_q;
      ext_d  = ext_q;
      if (load_ok) begin
         base_d = pcr_load_base;
         ext_d  = pcr_load_ext;
      end else if (rise) begin
         if (ext_q == EXT_WIDTH'(EXT_MOD - 1)) begin
            ext_d  = '0;
            base_d = base_q + 1'b1;
         end else begin
            ext_d = ext_q + 1'b1;
         end
      end

      // Error is only meaningful when the bases are at most one 90 kHz tick apart.
      db       = pcr_load_base - base_q;
      ext_diff = $signed(32'(pcr_load_ext)) - $signed(32'(ext_q));
      err      = ext_diff;
      err_oor  = 1'b0;
      if (db == BASE_WIDTH'(1))
         err = ext_diff + EXT_MOD;
      else if (db == '1)
         err = ext_diff - EXT_MOD;
      else if (db != '0)
         err_oor = 1'b1;

      disc_d = load_ok && (state_q == LOCKED) &&
               (err_oor || (err > DISC_THRESHOLD) || (err < -DISC_THRESHOLD));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk2) begin
      if (rst) begin
         state_q      <= UNLOCKED;
         prev_q       <= 1'b0;
         tick_q       <= 1'b0;
         ready_q      <= 1'b0;
         load_error_q <= 1'b0;
         disc_q       <= 1'b0;
         base_q       <= '0;
         ext_q        <= '0;
      end else begin
         prev_q       <= clk_pulse_in;
         tick_q       <= rise;
         ready_q      <= 1'b1;
         load_error_q <= load_bad;
         disc_q       <= disc_d;
         base_q       <= base_d;
         ext_q        <= ext_d;
         if (load_ok)
            state_q <= LOCKED;
      end
   end

   assign pcr_load_ready = ready_q;
   assign pcr_base       = base_q;
   assign pcr_ext        = ext_q;
   assign tick           = tick_q;
   assign locked         = (state_q == LOCKED);
   assign load_error     = load_error_q;
   assign discontinuity  = disc_q;

`ifdef PCR_JITTER_EN
   localparam logic signed [31:0] JMAX = (2 ** (JITTER_WIDTH - 1)) - 1;
   localparam logic signed [31:0] JMIN = -(2 ** (JITTER_WIDTH - 1));

   logic signed [JITTER_WIDTH-1:0] jitter_q, jitter_d;
   logic                           jv_q;

   // Out-of-range base difference saturates toward the sign of the difference.
   always_comb begin
      jitter_d = err[JITTER_WIDTH-1:0];
      if (err_oor)
         jitter_d = db[BASE_WIDTH-1] ? JMIN[JITTER_WIDTH-1:0] : JMAX[JITTER_WIDTH-1:0];
      else if (err > JMAX)
         jitter_d = JMAX[JITTER_WIDTH-1:0];
      else if (err < JMIN)
         jitter_d = JMIN[JITTER_WIDTH-1:0];
   end

   always_ff @(posedge clk2) begin
      if (rst) begin
         jitter_q <= '0;
         jv_q     <= 1'b0;
      end else begin
         jv_q <= load_ok && (state_q == LOCKED);
         if (load_ok && (state_q == LOCKED))
            jitter_q <= jitter_d;
      end
   end

   assign jitter       = jitter_q;
   assign jitter_valid = jv_q;
`else
   assign jitter       = '0;
   assign jitter_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pcr_clock_counter.sv
// Directed bench for pcr_clock_counter: counting, wrap, lock, load errors,
// discontinuity, jitter (when PCR_JITTER_EN is defined) and reset.
module tb_pcr_clock_counter;

`ifdef PCR_JITTER_EN
   localparam bit JEN = 1'b1;
`else
   localparam bit JEN = 1'b0;
`endif

   logic        clk2 = 1'b0;
   logic        rst = 1'b1;
   logic        clk_pulse_in = 1'b0;
   logic        pcr_load_valid = 1'b0;
   logic        pcr_load_ready;
   logic [32:0] pcr_load_base = '0;
   logic [8:0]  pcr_load_ext = '0;
   logic [32:0] pcr_base;
   logic [8:0]  pcr_ext;
   logic        tick, locked, load_error, discontinuity, jitter_valid;
   logic signed [15:0] jitter;

   int n_vec = 0;
   int n_err = 0;
   bit wave_on = 1'b0;
   int ph = 0;

   always #5 clk2 = ~clk2;

   pcr_clock_counter dut (
      .clk2           (clk2),
      .rst            (rst),
      .clk_pulse_in   (clk_pulse_in),
      .pcr_load_valid (pcr_load_valid),
      .pcr_load_ready (pcr_load_ready),
      .pcr_load_base  (pcr_load_base),
      .pcr_load_ext   (pcr_load_ext),
      .pcr_base       (pcr_base),
      .pcr_ext        (pcr_ext),
      .tick           (tick),
      .locked         (locked),
      .load_error     (load_error),
      .discontinuity  (discontinuity),
      .jitter         (jitter),
      .jitter_valid   (jitter_valid)
   );

   // Square wave of period 4: high for phases 0 and 1.
   task automatic step();
      clk_pulse_in = wave_on && (ph < 2);
      ph = (ph + 1) % 4;
      @(posedge clk2);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [32:0] b, input logic [8:0] e);
      pcr_load_valid = 1'b1;
      pcr_load_base  = b;
      pcr_load_ext   = e;
      step();
      pcr_load_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      run(3);
      check("rst_ready", 64'(pcr_load_ready), 64'd0);
      check("rst_base", 64'(pcr_base), 64'd0);
      check("rst_ext", 64'(pcr_ext), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
      rst = 1'b0;
      step();
      check("ready_after_rst", 64'(pcr_load_ready), 64'd1);
      check("tick_idle", 64'(tick), 64'd0);

      wave_on = 1'b1;
      ph = 0;
      step();
      check("first_tick", 64'(tick), 64'd1);
      check("first_ext", 64'(pcr_ext), 64'd1);
      step();
      check("tick_pulse_1cyc", 64'(tick), 64'd0);
      run(1191);
      check("tick_299", 64'(tick), 64'd1);
      check("ext_299", 64'(pcr_ext), 64'd299);
      check("base_0", 64'(pcr_base), 64'd0);
      run(4);
      check("tick_300", 64'(tick), 64'd1);
      check("base_roll", 64'(pcr_base), 64'd1);
      check("ext_roll", 64'(pcr_ext), 64'd0);
      wave_on = 1'b0;
      step();
      check("tick_off", 64'(tick), 64'd0);
      check("unlocked", 64'(locked), 64'd0);

      load(33'd1000, 9'd50);
      check("lock_locked", 64'(locked), 64'd1);
      check("lock_base", 64'(pcr_base), 64'd1000);
      check("lock_ext", 64'(pcr_ext), 64'd50);
      check("lock_no_jv", 64'(jitter_valid), 64'd0);
      check("lock_no_disc", 64'(discontinuity), 64'd0);

      load(33'd1000, 9'd10);
      check("jit_neg40", {48'h0, jitter}, JEN ? 64'hFFD8 : 64'h0);
      check("jv_neg40", 64'(jitter_valid), 64'(JEN));
      load(33'd1000, 9'd15);
      check("jit_plus5", {48'h0, jitter}, JEN ? 64'h5 : 64'h0);
      check("jv_plus5", 64'(jitter_valid), 64'(JEN));
      check("disc_plus5", 64'(discontinuity), 64'd0);
      step();
      check("jv_pulse", 64'(jitter_valid), 64'd0);
      check("jit_hold", {48'h0, jitter}, JEN ? 64'h5 : 64'h0);

      load(33'd1000, 9'd290);
      check("jit_275", {48'h0, jitter}, JEN ? 64'h113 : 64'h0);
      load(33'd1001, 9'd0);
      check("jit_plus10", {48'h0, jitter}, JEN ? 64'hA : 64'h0);
      check("base_1001", 64'(pcr_base), 64'd1001);

      load(33'd7, 9'd300);
      check("lerr_pulse", 64'(load_error), 64'd1);
      check("lerr_base", 64'(pcr_base), 64'd1001);
      check("lerr_ext", 64'(pcr_ext), 64'd0);
      check("lerr_no_jv", 64'(jitter_valid), 64'd0);
      check("lerr_jit_hold", {48'h0, jitter}, JEN ? 64'hA : 64'h0);
      step();
      check("lerr_clear", 64'(load_error), 64'd0);

      load(33'd1000, 9'd0);
      check("jit_neg300", {48'h0, jitter}, JEN ? 64'hFED4 : 64'h0);
      check("disc_neg300", 64'(discontinuity), 64'd0);
      load(33'd5000, 9'd0);
      check("disc_fwd", 64'(discontinuity), 64'd1);
      check("jit_sat_pos", {48'h0, jitter}, JEN ? 64'h7FFF : 64'h0);
      step();
      check("disc_pulse", 64'(discontinuity), 64'd0);
      load(33'd0, 9'd0);
      check("disc_back", 64'(discontinuity), 64'd1);
      check("jit_sat_neg", {48'h0, jitter}, JEN ? 64'h8000 : 64'h0);

      load(33'h1_FFFF_FFFF, 9'd299);
      check("jit_neg1", {48'h0, jitter}, JEN ? 64'hFFFF : 64'h0);
      check("disc_neg1", 64'(discontinuity), 64'd0);
      check("max_base", 64'(pcr_base), 64'h1_FFFF_FFFF);
      wave_on = 1'b1;
      ph = 0;
      step();
      check("wrap_tick", 64'(tick), 64'd1);
      check("wrap_base", 64'(pcr_base), 64'd0);
      check("wrap_ext", 64'(pcr_ext), 64'd0);
      run(3);
      check("gap_ext", 64'(pcr_ext), 64'd0);

      load(33'd2000, 9'd100);
      check("coin_tick", 64'(tick), 64'd1);
      check("coin_base", 64'(pcr_base), 64'd2000);
      check("coin_ext", 64'(pcr_ext), 64'd100);
      check("coin_disc", 64'(discontinuity), 64'd1);
      run(4);
      check("coin_next_tick", 64'(tick), 64'd1);
      check("coin_next_ext", 64'(pcr_ext), 64'd101);

      rst = 1'b1;
      wave_on = 1'b0;
      step();
      check("mid_rst_base", 64'(pcr_base), 64'd0);
      check("mid_rst_ext", 64'(pcr_ext), 64'd0);
      check("mid_rst_locked", 64'(locked), 64'd0);
      check("mid_rst_ready", 64'(pcr_load_ready), 64'd0);
      check("mid_rst_tick", 64'(tick), 64'd0);
      check("mid_rst_jit", {48'h0, jitter}, 64'h0);
      rst = 1'b0;
      step();
      check("post_rst_ready", 64'(pcr_load_ready), 64'd1);
      check("post_rst_locked", 64'(locked), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
